pwm_cmd_ramp: RTL and testbench

//  Slew-rate limiter that sits directly upstream of the PWM core and drives its 16-bit data_in.

---
 rtl/pwm_cmd_ramp.sv | 151 +++++++++++++++
 tb/tb_pwm_cmd_ramp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cmd_ramp.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cmd_ramp
// Purpose  : Slew-rate limiter feeding the PWM core's 16-bit data_in.
//            Accepts {dir, mag[14:0]} targets over a valid/ready handshake.
//            Ramps the applied command toward the target by STEP per tick.
//            On a direction change it ramps to zero, holds DEAD_TICKS ticks
//            at zero, then flips direction and ramps back up.
// Ports    : clk        in   system clock
//            rst        in   synchronous active-high reset
//            tgt_valid  in   target word valid
//            tgt_data   in   target word {dir, mag[14:0]}
//            tgt_ready  out  target can be accepted (equals settled)
//            cmd_out    out  applied command {dir, mag}
//            settled    out  tracking and command equals latched target
//            reversing  out  high while decelerating or in dead time
// Revision : 1.0 - initial release
// ============================================================================
module pwm_cmd_ramp #(
  parameter int TICK_DIV   = 2000,
  parameter int STEP       = 10,
  parameter int DEAD_TICKS = 5,
  parameter int MAX_MAG    = 32767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tgt_valid,
  input  logic [15:0] tgt_data,
  output logic        tgt_ready,
  output logic [15:0] cmd_out,
  output logic        settled,
  output logic        reversing
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_TICKS);
  localparam logic [14:0]   STEP_C    = 15'(STEP);
  localparam logic [14:0]   MAX_C     = 15'(MAX_MAG);

  typedef enum logic [1:0] {
    S_TRACK = 2'd0,
    S_DECEL = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc;
  logic [14:0]     mag, mag_n;
  logic            cur_dir, dir_n;
  logic            tgt_dir, tdir_n;
  logic [14:0]     tgt_mag, tmag_n;
  logic [DW-1:0]   dead_cnt, dead_n;
  logic            tick;
  logic            accept;
  logic [14:0]     diff;
  logic [14:0]     step_amt;
  logic [14:0]     toward;
  logic [14:0]     down;
  logic            settled_n;

  assign tick      = (presc == TICK_LAST);
  assign accept    = tgt_valid && tgt_ready;
  assign tgt_ready = settled;
  assign cmd_out   = {cur_dir, mag};

  // Step clamped to the remaining distance so the ramp lands exactly.
  assign diff     = (tgt_mag > mag) ? (tgt_mag - mag) : (mag - tgt_mag);
  assign step_amt = (diff < STEP_C) ? diff : STEP_C;
  assign toward   = (tgt_mag > mag) ? (mag + step_amt) : (mag - step_amt);
  assign down     = (mag < STEP_C) ? 15'd0 : (mag - STEP_C);

  always_comb begin
    state_n = state;
    mag_n   = mag;
    dir_n   = cur_dir;
    dead_n  = dead_cnt;
    tdir_n  = tgt_dir;
    tmag_n  = tgt_mag;

    // Tick logic uses the target latched before this edge, so a tick that
    // coincides with a transfer acts on the old target.
    if (tick) begin
      case (state)
        S_TRACK: begin
          if (tgt_dir == cur_dir || tgt_mag == 15'd0) begin
            mag_n = toward;
          end else if (mag != 15'd0) begin
            state_n = S_DECEL;
          end else begin
            state_n = S_DEAD;
            dead_n  = DEAD_INIT;
          end
        end
        S_DECEL: begin
          mag_n = down;
          if (down == 15'd0) begin
            state_n = S_DEAD;
            dead_n  = DEAD_INIT;
          end
        end
        S_DEAD: begin
          dead_n = dead_cnt - DW'(1);
          if (dead_cnt == DW'(1)) begin
            dir_n   = tgt_dir;
            state_n = S_TRACK;
          end
        end
        default: state_n = S_TRACK;
      endcase
    end

    if (accept) begin
      tdir_n = tgt_data[15];
      tmag_n = (tgt_data[14:0] > MAX_C) ? MAX_C : tgt_data[14:0];
    end
  end

  // A zero-magnitude target carries no meaningful direction: reaching zero
  // in either direction counts as settled, otherwise the block would never
  // reopen its handshake after a "stop in the other direction" target.
  assign settled_n = (state_n == S_TRACK) && (mag_n == tmag_n) &&
                     ((dir_n == tdir_n) || (tmag_n == 15'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_TRACK;
      presc     <= '0;
      mag       <= '0;
      cur_dir   <= 1'b0;
      tgt_dir   <= 1'b0;
      tgt_mag   <= '0;
      dead_cnt  <= '0;
      settled   <= 1'b1;
      reversing <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= tick ? '0 : (presc + PW'(1));
      mag       <= mag_n;
      cur_dir   <= dir_n;
      tgt_dir   <= tdir_n;
      tgt_mag   <= tmag_n;
      dead_cnt  <= dead_n;
      settled   <= settled_n;
      reversing <= (state_n != S_TRACK);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_cmd_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_cmd_ramp
// Purpose  : Self-checking bench for pwm_cmd_ramp. A trajectory model turns
//            each accepted target into the list of per-tick command values
//            and replays it against the DUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_cmd_ramp;

  localparam int TICK_DIV   = 4;
  localparam int STEP       = 10;
  localparam int DEAD_TICKS = 2;
  localparam int MAX_MAG    = 500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tgt_valid = 1'b0;
  logic [15:0] tgt_data = 16'h0000;
  logic        tgt_ready;
  logic [15:0] cmd_out;
  logic        settled;
  logic        reversing;

  pwm_cmd_ramp #(
    .TICK_DIV(TICK_DIV), .STEP(STEP), .DEAD_TICKS(DEAD_TICKS), .MAX_MAG(MAX_MAG)
  ) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready), .cmd_out(cmd_out), .settled(settled),
    .reversing(reversing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  bit saw_rev  = 1'b0;
  bit saw_flip = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- trajectory model ----------------
  // Each queue entry is the {reversing, cmd} pair seen after one future tick.
  logic [16:0] q[$];
  logic [15:0] m_cmd  = 16'h0000;
  logic        m_rev  = 1'b0;
  int          m_presc = 0;

  task automatic plan(input bit d, input int m, input bit td, input int tm);
    int cur;
    cur = m;
    if (td == d || tm == 0) begin
      while (cur != tm) begin
        if (tm > cur) cur = (cur + STEP > tm) ? tm : cur + STEP;
        else          cur = (cur - STEP < tm) ? tm : cur - STEP;
        q.push_back({1'b0, d, 15'(cur)});
      end
    end else begin
      if (cur > 0) begin
        q.push_back({1'b1, d, 15'(cur)});     // tick that enters deceleration
        while (cur > 0) begin
          cur = (cur > STEP) ? cur - STEP : 0;
          q.push_back({1'b1, d, 15'(cur)});
        end
      end else begin
        q.push_back({1'b1, d, 15'd0});        // straight into dead time
      end
      for (int k = 1; k < DEAD_TICKS; k++) q.push_back({1'b1, d, 15'd0});
      q.push_back({1'b0, td, 15'd0});         // direction flips at zero
      while (cur < tm) begin
        cur = (cur + STEP > tm) ? tm : cur + STEP;
        q.push_back({1'b0, td, 15'(cur)});
      end
    end
  endtask

  always @(posedge clk) begin
    bit          acc;
    logic [16:0] e;
    int          tm;
    if (rst) begin
      m_cmd = 16'h0000; m_rev = 1'b0; m_presc = 0; q.delete();
    end else begin
      acc = tgt_valid && (q.size() == 0);
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0;
        if (q.size() > 0) begin
          e = q.pop_front();
          m_rev = e[16];
          m_cmd = e[15:0];
        end
      end else begin
        m_presc++;
      end
      if (acc) begin
        tm = (int'(tgt_data[14:0]) > MAX_MAG) ? MAX_MAG : int'(tgt_data[14:0]);
        plan(m_cmd[15], int'(m_cmd[14:0]), tgt_data[15], tm);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmd_out",   cmd_out,   m_cmd);
      check("reversing", reversing, m_rev);
      check("settled",   settled,   q.size() == 0);
      check("tgt_ready", tgt_ready, q.size() == 0);
      if (reversing) saw_rev = 1'b1;
      if (cmd_out == 16'h8000) saw_flip = 1'b1;
    end
  end

  // ---------------- directed helpers (called at a negedge) ----------------
  task automatic do_reset(input int n);
    rst = 1'b1; tgt_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("rst_cmd",       cmd_out,   32'h0);
      check("rst_ready",     tgt_ready, 32'h1);
      check("rst_settled",   settled,   32'h1);
      check("rst_reversing", reversing, 32'h0);
    end
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    check("ready_before_send", tgt_ready, 32'h1);
    tgt_valid = 1'b1; tgt_data = d;
    @(negedge clk);
    tgt_valid = 1'b0; tgt_data = 16'($urandom);
  endtask

  task automatic wait_settled(input int maxc, output int cyc);
    cyc = 0;
    while (!settled && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    check("settle_timeout", settled, 32'h1);
  endtask

  task automatic wait_decel(input int want_mag, input int maxc);
    int cyc;
    cyc = 0;
    while (!(reversing && int'(cmd_out[14:0]) == want_mag) && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_reversing_point", {31'd0, reversing && int'(cmd_out[14:0]) == want_mag}, 32'h1);
  endtask

  initial begin
    int cyc;
    @(negedge clk); @(negedge clk);
    cmp_en = 1'b1;

    // 1: reset held three cycles
    do_reset(3);

    // 2: ramp 0 -> 200
    send(16'h00C8);
    check("ready_falls", tgt_ready, 32'h0);
    wait_settled(200, cyc);
    check("ramp_up_cmd", cmd_out, 32'h00C8);
    check("ramp_up_model", m_cmd, 32'h00C8);
    check("ramp_up_time", {31'd0, cyc >= 77 && cyc <= 80}, 32'h1);

    // 3: reversal 200 fwd -> 100 rev
    saw_rev = 1'b0; saw_flip = 1'b0;
    send(16'h8064);
    wait_settled(400, cyc);
    check("rev_cmd", cmd_out, 32'h8064);
    check("rev_seen", {31'd0, saw_rev}, 32'h1);
    check("rev_flip_at_zero", {31'd0, saw_flip}, 32'h1);
    check("rev_time", {31'd0, cyc >= 129 && cyc <= 132}, 32'h1);

    // 4: step clamp and magnitude ceiling
    do_reset(1);
    send(16'h0007);
    wait_settled(10, cyc);
    check("small_step_cmd", cmd_out, 32'h0007);
    check("small_step_one_tick", {31'd0, cyc <= TICK_DIV}, 32'h1);
    send(16'h7FFF);
    wait_settled(300, cyc);
    check("clamp_cmd", cmd_out, 32'h01F4);

    // 5: zero target in the opposite direction never reverses
    send(16'h00C8);
    wait_settled(300, cyc);
    saw_rev = 1'b0;
    send(16'h8000);
    wait_settled(300, cyc);
    check("zero_opp_cmd", cmd_out, 32'h0000);
    check("zero_opp_no_rev", {31'd0, saw_rev}, 32'h0);

    // 6: reset during deceleration, then during dead time
    send(16'h00C8);
    wait_settled(300, cyc);
    send(16'h8064);
    wait_decel(100, 200);
    do_reset(1);
    send(16'h00C8);
    wait_settled(300, cyc);
    send(16'h8064);
    wait_decel(0, 300);
    do_reset(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      tgt_valid = ($urandom_range(0, 3) == 0);
      tgt_data  = {1'($urandom), ($urandom_range(0, 9) == 0) ? 15'h7FFF
                                                              : 15'($urandom_range(0, 620))};
      @(negedge clk);
    end
    rst = 1'b0; tgt_valid = 1'b0;
    @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
